pu_accumulator: RTL and testbench
=================================

Name: pu_accumulator

Overview:
- Downstream stage of the 4-lane processing unit (PU). Consumes the PU's 32-bit adder-tree result `data_out` one partial sum per beat.
- Accumulates NUM_PARTIALS consecutive partial sums into one neuron pre-activation, applies optional ReLU, and presents the result on a valid/ready output.
- Its `in_ready` is intended to gate the PU's `en`, so the PU stalls while this block holds a result.

Parameters:
- WIDTH, 32: data width of the partial sums, accumulator and result. Signed two's complement.
- NUM_PARTIALS, 4: partial sums per result. Legal range is 1 or more.
- CNT_W, $clog2(NUM_PARTIALS)+1: width of the beat counter. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  partial sum on in_data is valid this cycle.
- in_data  input  WIDTH  partial sum (PU data_out), signed.
- in_ready  output  1  block accepts a beat this cycle.
- relu_en  input  1  1 = apply ReLU to the result; sampled on the final beat.
- clr  input  1  synchronous discard of the partial accumulation.
- out_valid  output  1  out_data and out_ovf hold a completed result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  activated result, signed.
- out_ovf  output  1  a signed overflow occurred while accumulating this result.

Behaviour:
- Reset (clk edge with rst=1): state=ACC, acc=0, cnt=0, ovf_acc=0, out_valid=0, out_data=0, out_ovf=0. Reset overrides everything, including a pending result in OUT, which is dropped.
- Beat accepted = in_valid & in_ready.
- in_ready = 1 in ACC, 0 in OUT. Never depends on out_ready (no combinational path from out_ready to in_ready).
- ACC state, beat accepted, cnt < NUM_PARTIALS-1:
  - cnt==0: acc <= in_data, ovf_acc <= 0.
  - otherwise: acc <= acc + in_data, and ovf_acc is ORed with the overflow of this add.
  - cnt <= cnt+1.
- ACC state, beat accepted, cnt == NUM_PARTIALS-1 (final beat):
  - sum = (cnt==0 ? in_data : acc + in_data).
  - out_data <= (relu_en & sum[WIDTH-1]) ? 0 : sum.
  - out_ovf <= ovf_acc | overflow of this add (0 when NUM_PARTIALS=1).
  - out_valid <= 1, cnt <= 0, state <= OUT.
  - Latency: out_valid rises the cycle after the final beat is accepted.
- ACC state, no beat: all state holds.
- OUT state:
  - out_valid=1; out_data and out_ovf are stable until the handshake.
  - out_valid & out_ready: out_valid <= 0, state <= ACC; next cycle in_ready=1.
  - Minimum one bubble cycle between results.
  - in_valid is ignored in OUT (no beat accepted).
- Overflow definition: both operands have the same sign and the sum's sign differs. The sum wraps modulo 2^WIDTH; there is no saturation.
- clr:
  - In ACC: next state cnt=0, acc=0, ovf_acc=0. clr wins over a simultaneous beat, including the final beat; that beat is discarded and no result is produced.
  - In OUT: clr is ignored; the pending result still completes its handshake.
- relu_en is only meaningful on the final beat; it is don't-care otherwise.
- Counter never exceeds NUM_PARTIALS-1, so there is no wrap condition.

Test Plan:
1. NUM_PARTIALS=4, relu_en=0, back-to-back beats 1,2,3,4, out_ready=1 -> out_valid one cycle after the 4th beat, out_data=10, out_ovf=0; in_ready=0 for exactly one cycle.
2. Beats -1,-2,-3,0: relu_en=0 -> out_data=0xFFFFFFFA; repeated with relu_en=1 -> out_data=0. out_ovf=0 in both.
3. Beats 0x7FFFFFFF,1,0,0 with relu_en=0 -> out_data=0x80000000, out_ovf=1. Repeated with relu_en=1 -> out_data=0, out_ovf=1. The next result, beats 1,1,1,1 -> out_data=4, out_ovf=0.
4. Backpressure: complete a result with out_ready=0 for 6 cycles while in_valid=1 with in_data=99 -> in_ready=0, out_data stable, no beats consumed. Then out_ready=1 -> out_valid drops next cycle, and the following beats start a fresh sum.
5. Beats 5,5, then clr, then beats 5,5,5,5 -> one result, out_data=20. Separately, clr asserted with the final beat -> no out_valid.
6. Reset while in OUT holding 10 -> next cycle out_valid=0, out_data=0, in_ready=1. Beats 2,2,2,2 -> out_data=8. Also, in_valid gaps of 3 idle cycles between beats -> same result of 8.

Source files
------------

// File: rtl/pu_accumulator.sv
// Accumulates NUM_PARTIALS signed partial sums into one result, with optional ReLU and overflow flag.
// Latency: out_valid rises the cycle after the final beat is accepted; at least one bubble between results.
// Backpressure: in_ready drops while a result is held; it depends only on registered state, not on out_ready.
module pu_accumulator #(
  parameter int WIDTH        = 32,
  parameter int NUM_PARTIALS = 4,
  parameter int CNT_W        = $clog2(NUM_PARTIALS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             relu_en,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  // Beat index of the final partial sum of a result.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PARTIALS - 1);

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   acc_q,       acc_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               ovf_acc_q,   ovf_acc_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q,  out_data_d;
  logic               out_ovf_q,   out_ovf_d;

  logic               beat;
  logic               first_beat;
  logic               last_beat;
  logic [WIDTH-1:0]   add_sum;
  logic               add_ovf;
  logic [WIDTH-1:0]   final_sum;
  logic               final_ovf;

  // Input side is open only in ACC; registered state keeps out_ready off this path.
  assign in_ready   = (state_q == ST_ACC);
  assign beat       = in_valid & in_ready;
  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == LAST_CNT);

  // Signed add with wraparound; overflow when operand signs agree but the sum's sign differs.
  assign add_sum = acc_q + in_data;
  assign add_ovf = (acc_q[WIDTH-1] == in_data[WIDTH-1]) &
                   (add_sum[WIDTH-1] != acc_q[WIDTH-1]);

  // A single-beat result (NUM_PARTIALS=1) passes the input straight through with no add.
  assign final_sum = first_beat ? in_data : add_sum;
  assign final_ovf = first_beat ? 1'b0 : (ovf_acc_q | add_ovf);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Next-state logic: accumulate beats in ACC, hold the result in OUT until it is taken.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_acc_d   = ovf_acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      ST_ACC: begin
        if (clr) begin
          // Discard wins even over the final beat: no result is produced.
          acc_d     = '0;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
        end else if (beat) begin
          if (last_beat) begin
            out_data_d  = (relu_en & final_sum[WIDTH-1]) ? '0 : final_sum;
            out_ovf_d   = final_ovf;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_OUT;
          end else begin
            if (first_beat) begin
              acc_d     = in_data;
              ovf_acc_d = 1'b0;
            end else begin
              acc_d     = add_sum;
              ovf_acc_d = ovf_acc_q | add_ovf;
            end
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_OUT: begin
        // clr and in_valid are ignored here; only the output handshake moves us on.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: begin
        state_d     = ST_ACC;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_pu_accumulator.sv
// Bench for pu_accumulator: vector table, directed multi-cycle sequences, randomized run vs reference model.
// Inputs change and outputs are sampled on the falling clock edge.
// Every wait on the design is bounded by a cycle budget.
module tb_pu_accumulator;

  localparam int W  = 32;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          relu_en;
  logic          clr;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  pu_accumulator #(.WIDTH(W), .NUM_PARTIALS(NP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .relu_en   (relu_en),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Present one beat starting at a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input logic [W-1:0] d, input logic r);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    relu_en  = r;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("beat_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for a result, compare it, and take it with a one-cycle out_ready pulse.
  task automatic take_result(input string name, input logic [W-1:0] exp_d, input logic exp_o);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({name, "_timeout"}, 32'd0, 32'd1);
    check({name, "_data"}, out_data, exp_d);
    check({name, "_ovf"}, {31'd0, out_ovf}, {31'd0, exp_o});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0][W-1:0] b;
    logic              relu;
    logic [W-1:0]      exp_d;
    logic              exp_o;
  } vec_t;

  vec_t vecs[7];

  // Reference model state: beats collected so far plus the pending result, if any.
  logic [W-1:0] m_beats[$];
  logic         m_pend;
  logic [W-1:0] m_data;
  logic         m_ovf;

  task automatic model_result(input logic r);
    longint sum_l;
    logic [W-1:0] acc;
    logic ovf = 1'b0;
    acc = m_beats[0];
    for (int i = 1; i < m_beats.size(); i++) begin
      sum_l = longint'($signed(acc)) + longint'($signed(m_beats[i]));
      if (sum_l > 64'sd2147483647 || sum_l < -64'sd2147483648) ovf = 1'b1;
      acc = sum_l[W-1:0];
    end
    m_data = (r && $signed(acc) < 0) ? '0 : acc;
    m_ovf  = ovf;
  endtask

  initial begin
    vecs[0] = '{b: {32'd4, 32'd3, 32'd2, 32'd1}, relu: 1'b0, exp_d: 32'd10, exp_o: 1'b0};
    vecs[1] = '{b: {32'd0, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF}, relu: 1'b0, exp_d: 32'hFFFFFFFA, exp_o: 1'b0};
    vecs[2] = '{b: {32'd0, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF}, relu: 1'b1, exp_d: 32'd0, exp_o: 1'b0};
    vecs[3] = '{b: {32'd0, 32'd0, 32'd1, 32'h7FFFFFFF}, relu: 1'b0, exp_d: 32'h80000000, exp_o: 1'b1};
    vecs[4] = '{b: {32'd0, 32'd0, 32'd1, 32'h7FFFFFFF}, relu: 1'b1, exp_d: 32'd0, exp_o: 1'b1};
    vecs[5] = '{b: {32'd1, 32'd1, 32'd1, 32'd1}, relu: 1'b0, exp_d: 32'd4, exp_o: 1'b0};
    vecs[6] = '{b: {32'd5, 32'd5, 32'd5, 32'd5}, relu: 1'b0, exp_d: 32'd20, exp_o: 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; relu_en = 1'b0; clr = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back beats with out_ready held: in_ready low for exactly one cycle.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      @(negedge clk);
      if (i < 4) check("b2b_no_early_valid", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    check("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("b2b_data", out_data, 32'd10);
    check("b2b_ovf", {31'd0, out_ovf}, 32'd0);
    @(negedge clk);
    check("b2b_valid_drop", {31'd0, out_valid}, 32'd0);
    check("b2b_in_ready_back", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Vector table.
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 4; k++) send_beat(vecs[v].b[k], vecs[v].relu);
      take_result($sformatf("vec%0d", v), vecs[v].exp_d, vecs[v].exp_o);
    end

    // Backpressure: held result, input blocked and data stable.
    send_beat(32'd1, 1'b0); send_beat(32'd2, 1'b0); send_beat(32'd3, 1'b0); send_beat(32'd4, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", out_data, 32'd10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_valid_drop", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) send_beat(32'd1, 1'b0);
    take_result("bp_fresh", 32'd4, 1'b0);

    // clr mid-accumulation.
    send_beat(32'd5, 1'b0); send_beat(32'd5, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 3; k++) send_beat(32'd5, 1'b0);
    check("clr_no_early_valid", {31'd0, out_valid}, 32'd0);
    send_beat(32'd5, 1'b0);
    take_result("clr_mid", 32'd20, 1'b0);

    // clr together with the final beat: no result.
    for (int k = 0; k < 3; k++) send_beat(32'd1, 1'b0);
    in_valid = 1'b1; in_data = 32'd1; clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("clr_final_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) send_beat(32'd2, 1'b0);
    take_result("clr_final_after", 32'd8, 1'b0);

    // Reset while holding a result.
    for (int k = 1; k <= 4; k++) send_beat(W'(k), 1'b0);
    check("rst_hold_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid2", {31'd0, out_valid}, 32'd0);
    check("rst_out_data2", out_data, 32'd0);
    check("rst_in_ready2", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) send_beat(32'd2, 1'b0);
    take_result("post_rst", 32'd8, 1'b0);

    // Idle gaps of three cycles between beats.
    for (int k = 0; k < 4; k++) begin
      send_beat(32'd2, 1'b0);
      if (k < 3) repeat (3) @(negedge clk);
    end
    take_result("gaps", 32'd8, 1'b0);

    // Randomized run against the reference model.
    m_beats.delete();
    m_pend = 1'b0; m_data = '0; m_ovf = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic [3:0] sel;
      check("rnd_out_valid", {31'd0, out_valid}, {31'd0, m_pend});
      check("rnd_in_ready", {31'd0, in_ready}, {31'd0, ~m_pend});
      if (m_pend) begin
        check("rnd_data", out_data, m_data);
        check("rnd_ovf", {31'd0, out_ovf}, {31'd0, m_ovf});
      end
      sel       = 4'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      clr       = ($urandom_range(0, 15) == 0);
      relu_en   = ($urandom_range(0, 1) != 0);
      if (sel < 4)      in_data = $urandom();
      else if (sel < 6) in_data = {1'b0, 31'($urandom())} | 32'h70000000;
      else if (sel < 8) in_data = 32'h80000000 | 32'($urandom_range(0, 255));
      else              in_data = 32'($signed($urandom_range(0, 200)) - 100);
      if (m_pend) begin
        if (out_ready) m_pend = 1'b0;
      end else if (clr) begin
        m_beats.delete();
      end else if (in_valid) begin
        m_beats.push_back(in_data);
        if (m_beats.size() == NP) begin
          model_result(relu_en);
          m_pend = 1'b1;
          m_beats.delete();
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
